// File: rtl/ibex_wb_pkg.sv
// Shared types and helpers for the Ibex-to-Wishbone bridges.
package ibex_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  localparam logic [3:0] WB_SEL_WORD = 4'hF;

  // Width of a counter that must reach 'cycles'; never narrower than one bit.
  function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ibex_instr_wb_bridge_if.sv
// Wishbone B4 classic bus as seen by a read master and its slave.
interface ibex_instr_wb_bridge_if #(
  parameter int unsigned AddrWidth = 32
);
  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [3:0]           sel;
  logic [AddrWidth-1:0] adr;
  logic [31:0]          dat;
  logic                 ack;
  logic                 err;

  modport master (output cyc, stb, we, sel, adr, input dat, ack, err);
  modport slave  (input cyc, stb, we, sel, adr, output dat, ack, err);
endinterface

// File: rtl/ibex_instr_wb_bridge.sv
// Instruction-fetch req/gnt/rvalid to single-outstanding Wishbone classic read master,
// with an optional bus timeout that turns a silent slave into an error response.
module ibex_instr_wb_bridge
  import ibex_wb_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 255,
  parameter int unsigned AddrWidth     = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 instr_req_i,
  input  logic [AddrWidth-1:0] instr_addr_i,
  output logic                 instr_gnt_o,
  output logic                 instr_rvalid_o,
  output logic [31:0]          instr_rdata_o,
  output logic                 instr_err_o,
  output logic                 busy_o,
  ibex_instr_wb_bridge_if.master wb
);

  localparam int unsigned CntWidth   = timeout_cnt_width(TimeoutCycles);
  localparam int unsigned LastCntInt = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(LastCntInt);
  localparam bit TimeoutEn = (TimeoutCycles != 0);

  wb_state_e             state_q, state_d;
  logic [AddrWidth-1:2]  addr_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic                  timeout;

  // Fetches are word-granular; the byte offset is deliberately dropped.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^instr_addr_i[1:0];

  assign timeout     = TimeoutEn && (cnt_q == LastCnt);
  assign instr_gnt_o = instr_req_i & ((state_q == IDLE) | (state_q == RESP));

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (instr_gnt_o) state_d = BUS;
      BUS:     if (wb.ack || wb.err || timeout) state_d = RESP;
      RESP:    state_d = instr_gnt_o ? BUS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (instr_gnt_o) begin
        addr_q <= instr_addr_i[AddrWidth-1:2];
        cnt_q  <= '0;
      end
      if (state_q == BUS) begin
        // A slave error dominates a simultaneous ack; either one beats the timeout.
        if (wb.err) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else if (wb.ack) begin
          rdata_q <= wb.dat;
          err_q   <= 1'b0;
        end else if (timeout) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else if (TimeoutEn) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign wb.cyc = (state_q == BUS);
  assign wb.stb = (state_q == BUS);
  assign wb.we  = 1'b0;
  assign wb.sel = WB_SEL_WORD;
  assign wb.adr = {addr_q, 2'b00};

  assign instr_rvalid_o = (state_q == RESP);
  assign instr_rdata_o  = rdata_q;
  assign instr_err_o    = err_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_ibex_instr_wb_bridge.sv
// Randomised and directed check of ibex_instr_wb_bridge against a transaction-level model.
module tb_ibex_instr_wb_bridge;

  localparam int TO_A = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_a, gnt_a, rvalid_a, err_a, busy_a;
  logic [31:0] addr_a, rdata_a;
  logic        req_b, gnt_b, rvalid_b, err_b, busy_b;
  logic [31:0] addr_b, rdata_b;

  ibex_instr_wb_bridge_if #(.AddrWidth(32)) wb_a ();
  ibex_instr_wb_bridge_if #(.AddrWidth(32)) wb_b ();

  ibex_instr_wb_bridge #(.TimeoutCycles(TO_A), .AddrWidth(32)) dut_a (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req_a), .instr_addr_i(addr_a),
    .instr_gnt_o(gnt_a), .instr_rvalid_o(rvalid_a), .instr_rdata_o(rdata_a),
    .instr_err_o(err_a), .busy_o(busy_a), .wb(wb_a)
  );

  ibex_instr_wb_bridge #(.TimeoutCycles(0), .AddrWidth(32)) dut_b (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req_b), .instr_addr_i(addr_b),
    .instr_gnt_o(gnt_b), .instr_rvalid_o(rvalid_b), .instr_rdata_o(rdata_b),
    .instr_err_o(err_b), .busy_o(busy_b), .wb(wb_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus cycles the transfer occupies: the slave's response cycle, capped by the timeout.
  function automatic int term_cycles(input int resp_n, input int t_cfg);
    if (resp_n == 0 || (t_cfg != 0 && resp_n > t_cfg)) return t_cfg;
    return resp_n;
  endfunction

  // Called at a negedge; raises req and expects the grant (bounded wait).
  task automatic issue(input logic [31:0] a);
    int w = 0;
    req_a = 1'b1;
    addr_a = a;
    wb_a.ack = 1'b0;
    wb_a.err = 1'b0;
    #1;
    while (!gnt_a && w < 8) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("gnt", gnt_a, 1);
  endtask

  // Plays the slave for one granted fetch; resp_n = 0 means the slave never answers.
  // Ends at the negedge of the response cycle.
  task automatic run_bus(input logic [31:0] a, input int resp_n, input bit use_ack,
                         input bit use_err, input logic [31:0] data);
    int          term;
    bit          timed_out;
    logic [31:0] exp_data;
    logic        exp_err;
    int cyc_cnt = 0, adr_bad = 0, rv_bad = 0, busy_bad = 0;
    term      = term_cycles(resp_n, TO_A);
    timed_out = (term != resp_n);
    exp_err   = use_err || timed_out;
    exp_data  = exp_err ? 32'h0 : data;
    @(negedge clk);
    req_a  = 1'b0;
    addr_a = $urandom;
    check("sel", {28'h0, wb_a.sel}, 32'hF);
    check("we", {31'h0, wb_a.we}, 0);
    for (int i = 1; i <= term; i++) begin
      if (i > 1) @(negedge clk);
      cyc_cnt  += int'(wb_a.cyc && wb_a.stb);
      adr_bad  += int'(wb_a.adr !== {a[31:2], 2'b00});
      rv_bad   += int'(rvalid_a);
      busy_bad += int'(!busy_a);
      wb_a.ack = (i == resp_n) && use_ack;
      wb_a.err = (i == resp_n) && use_err;
      wb_a.dat = (i == resp_n) ? data : $urandom;
    end
    @(negedge clk);
    wb_a.ack = 1'b0;
    wb_a.err = 1'b0;
    check("cyc_cycles", cyc_cnt, term);
    check("adr_stable", adr_bad, 0);
    check("rvalid_early", rv_bad, 0);
    check("busy_bus", busy_bad, 0);
    check("rvalid", rvalid_a, 1);
    check("cyc_in_resp", wb_a.cyc, 0);
    check("busy_resp", busy_a, 1);
    check("rdata", rdata_a, exp_data);
    check("err", err_a, exp_err);
  endtask

  // Idle cycles with stray ack/err pulses, which the bridge must ignore.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_rvalid", rvalid_a, 0);
      check("idle_cyc", wb_a.cyc, 0);
      check("idle_busy", busy_a, 0);
      wb_a.ack = 1'($urandom_range(0, 1));
      wb_a.err = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] cur_addr, nxt_addr, d;
    int          resp_n, gap, cyc_cnt;
    bit          use_ack, use_err;

    rst = 1'b1;
    req_a = 1'b0; addr_a = '0; req_b = 1'b0; addr_b = '0;
    wb_a.ack = 1'b0; wb_a.err = 1'b0; wb_a.dat = '0;
    wb_b.ack = 1'b0; wb_b.err = 1'b0; wb_b.dat = '0;
    repeat (3) @(negedge clk);
    check("rst_cyc", wb_a.cyc, 0);
    check("rst_stb", wb_a.stb, 0);
    check("rst_rvalid", rvalid_a, 0);
    check("rst_err", err_a, 0);
    check("rst_rdata", rdata_a, 0);
    check("rst_busy", busy_a, 0);
    rst = 1'b0;

    // Single fetch, ack on the second bus cycle.
    @(negedge clk);
    issue(32'h0000_1006);
    run_bus(32'h0000_1006, 2, 1'b1, 1'b0, 32'hDEAD_BEEF);

    // Back-to-back with zero-wait acks: second grant lands in the first response cycle.
    idle(1);
    issue(32'h0000_0100);
    run_bus(32'h0000_0100, 1, 1'b1, 1'b0, 32'h1111_0001);
    issue(32'h0000_0104);
    run_bus(32'h0000_0104, 1, 1'b1, 1'b0, 32'h2222_0002);

    // Error together with ack, then a normal fetch.
    idle(2);
    issue(32'h0000_0200);
    run_bus(32'h0000_0200, 1, 1'b1, 1'b1, 32'h3333_3333);
    issue(32'h0000_0204);
    run_bus(32'h0000_0204, 3, 1'b1, 1'b0, 32'h4444_4444);

    // Silent slave times out; ack on the last allowed cycle still wins.
    idle(1);
    issue(32'h0000_0300);
    run_bus(32'h0000_0300, 0, 1'b0, 1'b0, 32'h0);
    idle(1);
    issue(32'h0000_0304);
    run_bus(32'h0000_0304, TO_A, 1'b1, 1'b0, 32'h5A5A_A5A5);

    // Reset in the middle of a bus cycle, followed by a late ack.
    idle(1);
    issue(32'h0000_0400);
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cyc", wb_a.cyc, 0);
    check("midrst_stb", wb_a.stb, 0);
    check("midrst_rvalid", rvalid_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_rdata", rdata_a, 0);
    rst = 1'b0;
    wb_a.ack = 1'b1;
    wb_a.dat = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_ack_rvalid", rvalid_a, 0);
    end
    wb_a.ack = 1'b0;

    // Random traffic: response delay 0 (silent) .. 6, random errors and gaps.
    idle(1);
    cur_addr = $urandom;
    issue(cur_addr);
    for (int k = 0; k < 40; k++) begin
      resp_n  = $urandom_range(0, 6);
      use_err = (resp_n != 0) && ($urandom_range(0, 3) == 0);
      use_ack = (resp_n != 0) && (use_err ? bit'($urandom_range(0, 1)) : 1'b1);
      d       = $urandom;
      run_bus(cur_addr, resp_n, use_ack, use_err, d);
      if (k < 39) begin
        gap = $urandom_range(0, 2);
        if (gap != 0) idle(gap);
        nxt_addr = $urandom;
        issue(nxt_addr);
        cur_addr = nxt_addr;
      end
    end

    // Timeout disabled: a very slow slave still returns data without error.
    @(negedge clk);
    req_b  = 1'b1;
    addr_b = 32'h0000_0803;
    #1;
    check("b_gnt", gnt_b, 1);
    @(negedge clk);
    req_b   = 1'b0;
    cyc_cnt = 0;
    for (int i = 1; i <= 1000; i++) begin
      if (i > 1) @(negedge clk);
      cyc_cnt += int'(wb_b.cyc);
      if (i == 1) check("b_adr", wb_b.adr, 32'h0000_0800);
      wb_b.ack = (i == 1000);
      wb_b.dat = (i == 1000) ? 32'hC0FF_EE00 : 32'h0;
    end
    @(negedge clk);
    wb_b.ack = 1'b0;
    check("b_cyc_cycles", cyc_cnt, 1000);
    check("b_rvalid", rvalid_b, 1);
    check("b_rdata", rdata_b, 32'hC0FF_EE00);
    check("b_err", err_b, 0);
    @(negedge clk);
    check("b_rvalid_once", rvalid_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
